lsu_mem_ctrl: RTL and testbench

- Load/store initiator between the multicycle core datapath and the word-organised data memory (WD, A, WE, RD; combinational read, write on posedge clk).
- Accepts one byte, halfword or word load/store per request.
- Sign- or zero-extends loads; sub-word stores use read-modify-write, because the memory has a single word-wide WE and no byte enables.
- Returns a response through a valid/ready handshake.

---
 rtl/lsu_mem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the core datapath and a word-organised
// data memory (combinational read, write on posedge). Byte/halfword stores are done
// as read-modify-write because the memory only has a single word-wide write enable.
//
// Build option: define LSU_MISALIGN_TRAP_EN to turn misaligned halfword/word accesses
// and unlisted funct3 codes into an error response with no memory access. When it is
// undefined, misaligned low address bits are masked to natural alignment and rsp_err
// is tied low.

module lsu_mem_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_A,
    output logic [31:0]       mem_WD,
    output logic              mem_WE,
    input  logic [31:0]       mem_RD
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRmwRd,
        StWrite,
        StResp
    } state_e;

    state_e            state_q;
    logic [1:0]        off_q;       // lane offset, already masked to natural alignment
    logic [2:0]        funct3_q;
    logic [15:0]       wdata_q;     // only the sub-word store paths need the latched data
    logic [ADDR_W-1:0] mem_a_q;
    logic [31:0]       mem_wd_q;
    logic              mem_we_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;

    logic       req_is_b;
    logic       req_is_h;
    logic [1:0] req_off;
    logic       req_trap;
    logic [7:0] lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merge_wd;

    // Decode access size of the incoming request; 011/110/111 fall through to word
    always_comb begin
        req_is_b = (req_funct3[1:0] == 2'b00);
        req_is_h = (req_funct3[1:0] == 2'b01);
        if (req_is_b) begin
            req_off = req_addr[1:0];
        end else if (req_is_h) begin
            req_off = {req_addr[1], 1'b0};
        end else begin
            req_off = 2'b00;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic rsp_err_q;

    // Misaligned halfword/word or an unlisted funct3 code is answered with an error
    always_comb begin
        req_trap = (req_is_h && req_addr[0]) ||
                   (!req_is_b && !req_is_h && (req_addr[1:0] != 2'b00)) ||
                   (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111);
    end

    assign rsp_err = rsp_err_q;
`else
    assign req_trap = 1'b0;
    assign rsp_err  = 1'b0;
`endif

    // Lane extraction, load extension and store-lane merge, all from the read word
    always_comb begin
        lane_b   = mem_RD[{off_q, 3'b000} +: 8];
        lane_h   = mem_RD[{off_q[1], 4'b0000} +: 16];
        load_ext = mem_RD;
        merge_wd = mem_RD;
        case (funct3_q[1:0])
            2'b00: begin
                load_ext = funct3_q[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
                merge_wd[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_ext = funct3_q[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
                merge_wd[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_ext = mem_RD;
                merge_wd = mem_RD;
            end
        endcase
    end

    // Controller FSM with registered memory-side and response-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            off_q       <= 2'b00;
            funct3_q    <= 3'b000;
            wdata_q     <= 16'h0000;
            mem_a_q     <= '0;
            mem_wd_q    <= 32'h0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        mem_a_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                        off_q    <= req_off;
                        funct3_q <= req_funct3;
                        wdata_q  <= req_wdata[15:0];
                        if (req_trap) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
                            rsp_err_q   <= 1'b1;
`endif
                        end else if (!req_we) begin
                            state_q <= StLoad;
                        end else if (req_is_b || req_is_h) begin
                            state_q <= StRmwRd;
                        end else begin
                            // Full-word store skips the read phase
                            state_q  <= StWrite;
                            mem_wd_q <= req_wdata;
                            mem_we_q <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    rsp_rdata_q <= load_ext;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StRmwRd: begin
                    mem_wd_q <= merge_wd;
                    mem_we_q <= 1'b1;
                    state_q  <= StWrite;
                end
                StWrite: begin
                    mem_we_q    <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_A     = mem_a_q;
    assign mem_WD    = mem_wd_q;
    // A write coinciding with reset must never reach the memory
    assign mem_WE    = mem_we_q & ~rst;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl with a small behavioural word memory.

module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    logic [31:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;
    int          we_cnt = 0;
    logic [31:0] last_wd;
    logic [31:0] last_wa;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_WE     (mem_WE),
        .mem_RD     (mem_RD)
    );

    // Word memory: combinational read, write on posedge; also records each write pulse
    assign mem_RD = mem[mem_A[7:2]];

    always @(posedge clk) begin
        if (mem_WE) begin
            mem[mem_A[7:2]] <= mem_WD;
            we_cnt          <= we_cnt + 1;
            last_wd         <= mem_WD;
            last_wa         <= mem_A;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_idx  = idx[5:0];
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        tick();
        req_valid  = 1'b0;
    endtask

    // Cycles counted from the accept edge; bounded so a stuck DUT still reaches the summary
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic op(input string tag, input logic we, input logic [31:0] addr,
                      input logic [2:0] f3, input logic [31:0] wd, input int exp_lat,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_wes);
        int lat;
        int base;
        base = we_cnt;
        issue(we, addr, f3, wd);
        wait_rsp(lat);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " rdata"}, rsp_rdata, exp_rdata);
        check({tag, " err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        handshake();
        check({tag, " ready after rsp"}, {31'b0, req_ready}, 32'd1);
        check({tag, " write pulses"}, we_cnt - base, exp_wes);
    endtask

    initial begin
        int lat;
        int base;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_funct3 = 3'b000;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        pl_en      = 1'b0;
        pl_idx     = 6'd0;
        pl_data    = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        check("reset req_ready", {31'b0, req_ready}, 32'd1);
        check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset rsp_err", {31'b0, rsp_err}, 32'd0);
        check("reset mem_A", mem_A, 32'h0);
        check("reset mem_WD", mem_WD, 32'h0);
        check("reset mem_WE", {31'b0, mem_WE}, 32'd0);

        preload(1, 32'h00400313);
        preload(2, 32'h02832393);
        preload(3, 32'h00038E63);
        preload(4, 32'h00000000);
        preload(8, 32'h11223344);

        // Loads of every size and extension
        op("LW 0x4",  1'b0, 32'h4, 3'b010, 32'h0, 2, 32'h00400313, 1'b0, 0);
        op("LB 0xC",  1'b0, 32'hC, 3'b000, 32'h0, 2, 32'h00000063, 1'b0, 0);
        op("LB 0xD",  1'b0, 32'hD, 3'b000, 32'h0, 2, 32'hFFFFFF8E, 1'b0, 0);
        op("LBU 0xD", 1'b0, 32'hD, 3'b100, 32'h0, 2, 32'h0000008E, 1'b0, 0);
        op("LB 0xF",  1'b0, 32'hF, 3'b000, 32'h0, 2, 32'h00000000, 1'b0, 0);
        op("LH 0xC",  1'b0, 32'hC, 3'b001, 32'h0, 2, 32'hFFFF8E63, 1'b0, 0);
        op("LHU 0xC", 1'b0, 32'hC, 3'b101, 32'h0, 2, 32'h00008E63, 1'b0, 0);
        op("LH 0xE",  1'b0, 32'hE, 3'b001, 32'h0, 2, 32'h00000003, 1'b0, 0);

        // Sub-word stores via read-modify-write
        op("SH 0xA", 1'b1, 32'hA, 3'b001, 32'h0000ABCD, 3, 32'h0, 1'b0, 1);
        check("SH write data", last_wd, 32'hABCD2393);
        check("SH write addr", last_wa, 32'h8);
        op("LW 0x8 after SH", 1'b0, 32'h8, 3'b010, 32'h0, 2, 32'hABCD2393, 1'b0, 0);
        op("SB 0x9", 1'b1, 32'h9, 3'b000, 32'h1234565A, 3, 32'h0, 1'b0, 1);
        check("SB write data", last_wd, 32'hABCD5A93);

        // Response backpressure on a full-word store
        base = we_cnt;
        issue(1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
        wait_rsp(lat);
        check("SW latency", lat, 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("backpressure rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("backpressure req_ready", {31'b0, req_ready}, 32'd0);
        end
        handshake();
        check("after SW req_ready", {31'b0, req_ready}, 32'd1);
        check("after SW rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("SW write pulses", we_cnt - base, 1);
        check("SW write data", last_wd, 32'hDEADBEEF);
        op("LW 0x10 after SW", 1'b0, 32'h10, 3'b010, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);

        // Reset landing in the WRITE cycle of a byte store
        base = we_cnt;
        issue(1'b1, 32'h20, 3'b000, 32'h00000055);
        tick();
        check("WRITE cycle mem_WE", {31'b0, mem_WE}, 32'd1);
        rst = 1'b1;
        #1;
        check("mem_WE gated by rst", {31'b0, mem_WE}, 32'd0);
        tick();
        rst = 1'b0;
        check("post-rst req_ready", {31'b0, req_ready}, 32'd1);
        check("post-rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("post-rst rsp_rdata", rsp_rdata, 32'h0);
        check("post-rst mem_A", mem_A, 32'h0);
        check("post-rst mem_WD", mem_WD, 32'h0);
        check("post-rst mem_WE", {31'b0, mem_WE}, 32'd0);
        check("post-rst write pulses", we_cnt - base, 0);
        op("LW 0x20 after rst", 1'b0, 32'h20, 3'b010, 32'h0, 2, 32'h11223344, 1'b0, 0);

        // Misaligned accesses and unlisted funct3
`ifdef LSU_MISALIGN_TRAP_EN
        op("LW 0x6 trap",   1'b0, 32'h6, 3'b010, 32'h0, 1, 32'h0, 1'b1, 0);
        op("LH 0xD trap",   1'b0, 32'hD, 3'b001, 32'h0, 1, 32'h0, 1'b1, 0);
        op("f3 011 trap",   1'b0, 32'h4, 3'b011, 32'h0, 1, 32'h0, 1'b1, 0);
        op("SW 0x12 trap",  1'b1, 32'h12, 3'b010, 32'hCAFEF00D, 1, 32'h0, 1'b1, 0);
        op("LW 0x10 kept",  1'b0, 32'h10, 3'b010, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);
`else
        op("LW 0x6 masked", 1'b0, 32'h6, 3'b010, 32'h0, 2, 32'h00400313, 1'b0, 0);
        op("LH 0xD masked", 1'b0, 32'hD, 3'b001, 32'h0, 2, 32'hFFFF8E63, 1'b0, 0);
        op("f3 011 as LW",  1'b0, 32'h4, 3'b011, 32'h0, 2, 32'h00400313, 1'b0, 0);
        op("SW 0x12 masked", 1'b1, 32'h12, 3'b010, 32'hCAFEF00D, 2, 32'h0, 1'b0, 1);
        op("LW 0x10 after", 1'b0, 32'h10, 3'b010, 32'h0, 2, 32'hCAFEF00D, 1'b0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
